// File: rtl/cache_refill_ctrl.sv
// rtl/cache_refill_ctrl.sv - read-request / line-refill controller for a direct-mapped cache array (option macro: REFILL_BYPASS_EN)
module cache_refill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 6,
    parameter int LINE_W = 128,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    output logic              REQ_READY,
    output logic              RSP_VALID,
    output logic [WORD_W-1:0] RSP_WORD,
    output logic              C_CEN,
    output logic              C_WORC,
    output logic [ADDR_W-1:0] C_A,
    output logic [IDX_W-1:0]  C_WA,
    output logic [LINE_W-1:0] C_D,
    input  logic [LINE_W-1:0] C_Q,
    input  logic              C_HIT,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic              MEM_RVALID,
    input  logic [WORD_W-1:0] MEM_RDATA
);

    localparam int BEATS    = LINE_W / WORD_W;
    localparam int BEAT_W   = $clog2(BEATS);
    localparam int BYTE_OFF = $clog2(WORD_W / 8);
    localparam int LINE_OFF = $clog2(LINE_W / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_MISS_REQ,
        S_FILL,
        S_WRITE
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr;
    logic [BEAT_W-1:0]  beat;
    logic [LINE_W-1:0]  fill_line;
    logic [LINE_W-1:0]  fill_next;
    logic [IDX_W-1:0]   idx;
    logic [BEAT_W-1:0]  wsel;

    assign idx  = addr[LINE_OFF +: IDX_W];
    assign wsel = addr[BYTE_OFF +: BEAT_W];

    function automatic logic [WORD_W-1:0] pick_word(input logic [LINE_W-1:0] line,
                                                    input logic [BEAT_W-1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

    // Fill line with the beat currently on MEM_RDATA merged into slot 'beat'
    always_comb begin
        fill_next = fill_line;
        fill_next[beat*WORD_W +: WORD_W] = MEM_RDATA;
    end

    // Request FSM; every output is a register updated alongside the state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            addr      <= '0;
            beat      <= '0;
            fill_line <= '0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_WORD  <= '0;
            C_CEN     <= 1'b1;
            C_WORC    <= 1'b1;
            C_A       <= '0;
            C_WA      <= '0;
            C_D       <= '0;
            MEM_REQ   <= 1'b0;
            MEM_ADDR  <= '0;
        end else begin
            // Cache is idle and the response strobe is a pulse unless a state below says otherwise
            RSP_VALID <= 1'b0;
            C_CEN     <= 1'b1;
            C_WORC    <= 1'b1;

            case (state)
                S_IDLE: begin
                    // Acceptance is gated by the registered ready so nothing is taken
                    // in the first cycle after reset release
                    if (REQ_READY && REQ_VALID) begin
                        addr      <= REQ_ADDR;
                        REQ_READY <= 1'b0;
                        C_CEN     <= 1'b0;
                        C_A       <= REQ_ADDR;
                        C_WA      <= REQ_ADDR[LINE_OFF +: IDX_W];
                        state     <= S_LOOKUP;
                    end else begin
                        REQ_READY <= 1'b1;
                    end
                end

                S_LOOKUP: begin
                    // Array registers the compare this cycle; result is visible in CHECK
                    state <= S_CHECK;
                end

                S_CHECK: begin
                    if (C_HIT) begin
                        RSP_WORD  <= pick_word(C_Q, wsel);
                        RSP_VALID <= 1'b1;
                        REQ_READY <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        MEM_REQ   <= 1'b1;
                        MEM_ADDR  <= {addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
                        state     <= S_MISS_REQ;
                    end
                end

                S_MISS_REQ: begin
                    // Beats seen here are not ours yet and are ignored
                    if (MEM_ACK) begin
                        MEM_REQ   <= 1'b0;
                        beat      <= '0;
                        fill_line <= '0;
                        state     <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (MEM_RVALID) begin
                        fill_line <= fill_next;
                        beat      <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            // Last beat: the complete line goes straight onto the write port
                            C_CEN  <= 1'b0;
                            C_WORC <= 1'b0;
                            C_WA   <= idx;
                            C_A    <= addr;
                            C_D    <= fill_next;
                            state  <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
`ifdef REFILL_BYPASS_EN
                    // Answer from the fill buffer instead of re-reading the array
                    RSP_WORD  <= pick_word(fill_line, wsel);
                    RSP_VALID <= 1'b1;
                    REQ_READY <= 1'b1;
                    state     <= S_IDLE;
`else
                    // Replay the compare; a miss here loops back through the refill path
                    C_CEN <= 1'b0;
                    C_A   <= addr;
                    C_WA  <= idx;
                    state <= S_LOOKUP;
`endif
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb/tb_cache_refill_ctrl.sv - directed scoreboard bench for cache_refill_ctrl with cache array and memory models
module tb_cache_refill_ctrl;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic [15:0]  req_addr;
    logic         req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_word;
    logic         c_cen;
    logic         c_worc;
    logic [15:0]  c_a;
    logic [5:0]   c_wa;
    logic [127:0] c_d;
    logic [127:0] c_q;
    logic         c_hit;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_ack;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    cache_refill_ctrl dut (
        .CLK        (clk),
        .RST        (rst),
        .REQ_VALID  (req_valid),
        .REQ_ADDR   (req_addr),
        .REQ_READY  (req_ready),
        .RSP_VALID  (rsp_valid),
        .RSP_WORD   (rsp_word),
        .C_CEN      (c_cen),
        .C_WORC     (c_worc),
        .C_A        (c_a),
        .C_WA       (c_wa),
        .C_D        (c_d),
        .C_Q        (c_q),
        .C_HIT      (c_hit),
        .MEM_REQ    (mem_req),
        .MEM_ADDR   (mem_addr),
        .MEM_ACK    (mem_ack),
        .MEM_RVALID (mem_rvalid),
        .MEM_RDATA  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_count = 0;
    int memreq_cycles = 0;
    logic [5:0]   wr_wa;
    logic [127:0] wr_d;

    typedef struct {
        logic [31:0] word;
        int          t;
        int          lat;
    } exp_t;
    exp_t sb[$];

    logic [127:0] lines [64];
    logic [5:0]   tags  [64];
    logic         valid [64];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Cache array model: registered compare/read, write on CEN low with WORC low, cleared by reset
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) valid[i] <= 1'b0;
            c_hit <= 1'b0;
            c_q   <= '0;
        end else if (!c_cen && c_worc) begin
            c_q   <= lines[c_a[9:4]];
            c_hit <= valid[c_a[9:4]] && (tags[c_a[9:4]] == c_a[15:10]);
        end else begin
            c_hit <= 1'b0;
            if (!c_cen && !c_worc) begin
                lines[c_wa] <= c_d;
                tags[c_wa]  <= c_a[15:10];
                valid[c_wa] <= 1'b1;
            end
        end
    end

    // Observers for write cycles and memory request activity
    always @(negedge clk) begin
        if (c_cen === 1'b0 && c_worc === 1'b0) begin
            wr_count++;
            wr_wa = c_wa;
            wr_d  = c_d;
        end
        if (mem_req === 1'b1) memreq_cycles++;
    end

    // Response scoreboard
    always @(negedge clk) begin
        if (!rst && rsp_valid === 1'b1) begin
            check("rsp_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_word", 128'(rsp_word), 128'(e.word));
                if (e.lat >= 0) check("rsp_latency", 128'(cyc - e.t), 128'(e.lat));
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rsp_word", 128'(rsp_word), 128'(0));
        check("rst_c_cen", 128'(c_cen), 128'(1));
        check("rst_c_worc", 128'(c_worc), 128'(1));
        check("rst_c_a", 128'(c_a), 128'(0));
        check("rst_c_wa", 128'(c_wa), 128'(0));
        check("rst_c_d", c_d, 128'(0));
        check("rst_mem_req", 128'(mem_req), 128'(0));
        check("rst_mem_addr", 128'(mem_addr), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 128'(req_ready), 128'(1));
    endtask

    task automatic send_req(input logic [15:0] a, input bit push, input logic [31:0] w,
                            input int lat, output int t);
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_addr  = a;
        t = cyc;
        if (push) sb.push_back('{w, t, lat});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic serve_mem(input logic [15:0] exp_addr, input int t, input int ack_delay,
                             input int gap, input bit early,
                             input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic [31:0] b3, input int nbeats);
        logic [31:0] bb [4];
        int n = 0;
        bit stable = 1'b1;
        bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
        while (mem_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("mem_req_seen", 128'(mem_req), 128'(1));
        check("mem_req_latency", 128'(cyc - t), 128'(3));
        check("mem_addr", 128'(mem_addr), 128'(exp_addr));
        for (int i = 0; i < ack_delay; i++) begin
            if (early && i == 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hDEADBEEF;
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr) stable = 1'b0;
        end
        check("mem_req_hold", 128'(stable), 128'(1));
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("mem_req_drop", 128'(mem_req), 128'(0));
        for (int k = 0; k < nbeats; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = bb[k];
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_drain", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        int t;
        int snap;
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = '0;
        mem_ack = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        @(negedge clk);
        do_reset();

        // Miss on an empty cache, back-to-back beats
        snap = wr_count;
        send_req(16'hAAAA, 1'b1, 32'h33333333, -1, t);
        serve_mem(16'hAAA0, t, 0, 0, 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 4);
        wait_idle();
        check("fill_write_count", 128'(wr_count - snap), 128'(1));
        check("fill_wa", 128'(wr_wa), 128'(6'h2A));
        check("fill_line", wr_d, 128'h44444444_33333333_22222222_11111111);

        // Hit on the freshly filled line
        snap = memreq_cycles;
        send_req(16'hAAA4, 1'b1, 32'h22222222, 3, t);
        wait_idle();
        check("hit_no_mem_req", 128'(memreq_cycles), 128'(snap));

        // Delayed ack, stray beat during the request phase, gapped beats
        snap = wr_count;
        send_req(16'h1238, 1'b1, 32'hC3C3C3C3, -1, t);
        serve_mem(16'h1230, t, 5, 2, 1'b1, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4, 4);
        wait_idle();
        check("gap_write_count", 128'(wr_count - snap), 128'(1));
        check("gap_wa", 128'(wr_wa), 128'(6'h23));
        check("gap_line", wr_d, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1);
        snap = memreq_cycles;
        send_req(16'h1230, 1'b1, 32'hA1A1A1A1, 3, t);
        wait_idle();
        check("gap_hit_no_mem_req", 128'(memreq_cycles), 128'(snap));

        // Reset after two beats: no write, no response, next request misses again
        do_reset();
        snap = wr_count;
        send_req(16'hAAAA, 1'b0, 32'h0, -1, t);
        serve_mem(16'hAAA0, t, 0, 0, 1'b0, 32'h01010101, 32'h02020202, 32'h0, 32'h0, 2);
        do_reset();
        check("abort_no_write", 128'(wr_count), 128'(snap));
        send_req(16'hAAAA, 1'b1, 32'h77777777, -1, t);
        serve_mem(16'hAAA0, t, 1, 1, 1'b0, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 4);
        wait_idle();
        check("refill_write_count", 128'(wr_count - snap), 128'(1));

        // Back-to-back: second request presented during the first response cycle
        send_req(16'hAAA0, 1'b1, 32'h55555555, 3, t);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_rsp", 128'(rsp_valid), 128'(1));
        check("b2b_ready_in_rsp", 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_addr  = 16'hAAAC;
        sb.push_back('{32'h88888888, cyc, 3});
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
